// File: rtl/program_memory_pkg.sv
// Shared definitions for the mini-processor program memory: opcodes, the
// default NOP instruction word and the loader FSM state encodings.
package program_memory_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_LCD = 4'd2;
    localparam logic [3:0] OP_JMP = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;

    // Opcode NOP with a 4000-cycle delay operand.
    localparam logic [27:0] DEFAULT_NOP_WORD = {OP_NOP, 24'd4000};

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        WRITE   = ST_WRITE,
        DONE    = ST_DONE
    } load_state_t;

    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/program_memory_loader.sv
// Byte-serial program loader: start validation, little-endian word assembly
// and write sequencing into the program RAM.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for load_start; fetches are served only here
//   COLLECT | accepting bytes into the assembly register (ready high)
//   WRITE   | one cycle: assembled word written at base + word index
//   DONE    | one cycle: load_done pulse, then back to IDLE
module program_memory_loader
    import program_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic                  clk_sys,
    input  logic                  rst_b,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_count,
    input  logic [7:0]            load_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error,
    output logic                  fsm_idle,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BW-1:0]         LAST_BYTE = BW'(BPW - 1);
    localparam logic [ADDR_WIDTH+1:0] DEPTH_EXT = (ADDR_WIDTH + 2)'(DEPTH);

    load_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [BW-1:0]         byte_idx;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [8*BPW-1:0]      asm_ext;
    logic                  err_q;
    logic [ADDR_WIDTH+1:0] load_end;
    logic                  start_zero;
    logic                  start_oob;
    logic                  start_go;
    logic                  last_word;

    // Two extra bits so base + count can never wrap before the bound check.
    assign load_end   = {2'b00, load_base} + {1'b0, load_count};
    assign start_zero = (load_count == '0);
    assign start_oob  = (load_end > DEPTH_EXT);
    assign start_go   = load_start && !start_zero && !start_oob;
    assign last_word  = ((word_idx + 1'b1) == count_q);

    assign wr_addr    = base_q + word_idx[ADDR_WIDTH-1:0];
    assign wr_data    = asm_q;
    assign load_error = err_q;

    always_comb begin
        asm_ext = (8*BPW)'(asm_q);
        asm_ext[8*byte_idx +: 8] = load_data;
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        load_busy  = 1'b1;
        load_done  = 1'b0;
        fsm_idle   = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                load_busy = 1'b0;
                fsm_idle  = 1'b1;
                if (load_start) begin
                    if (start_zero) begin
                        state_nxt = DONE;
                    end else if (!start_oob) begin
                        state_nxt = COLLECT;
                    end
                end
            end
            COLLECT: begin
                load_ready = 1'b1;
                if (load_valid && (byte_idx == LAST_BYTE)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_en     = 1'b1;
                state_nxt = last_word ? DONE : COLLECT;
            end
            DONE: begin
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            base_q   <= '0;
            count_q  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            asm_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && load_start && !start_zero && start_oob;
            case (state)
                IDLE: begin
                    if (start_go) begin
                        base_q   <= load_base;
                        count_q  <= load_count;
                        word_idx <= '0;
                        byte_idx <= '0;
                        asm_q    <= '0;
                    end
                end
                COLLECT: begin
                    if (load_valid) begin
                        // Truncation drops the bits above DATA_WIDTH in the top byte.
                        asm_q    <= DATA_WIDTH'(asm_ext);
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    byte_idx <= '0;
                    asm_q    <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/program_memory.sv
// Runtime-loadable instruction memory: registered one-cycle fetch port plus a
// byte-serial loader writing into a simple synchronous RAM.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(DEFAULT_NOP_WORD)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iFetchEnable,
    input  logic [ADDR_WIDTH-1:0] iFetchAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oInstructionValid,
    input  logic                  iLoadStart,
    input  logic [ADDR_WIDTH-1:0] iLoadBase,
    input  logic [ADDR_WIDTH:0]   iLoadCount,
    input  logic [7:0]            iLoadData,
    input  logic                  iLoadValid,
    output logic                  oLoadReady,
    output logic                  oLoadBusy,
    output logic                  oLoadDone,
    output logic                  oLoadError
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  fsm_idle;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  fetch_in_range;

    program_memory_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_loader (
        .clk_sys    (Clock),
        .rst_b      (Reset),
        .load_start (iLoadStart),
        .load_base  (iLoadBase),
        .load_count (iLoadCount),
        .load_data  (iLoadData),
        .load_valid (iLoadValid),
        .load_ready (oLoadReady),
        .load_busy  (oLoadBusy),
        .load_done  (oLoadDone),
        .load_error (oLoadError),
        .fsm_idle   (fsm_idle),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    // No reset on the array: loaded programs survive a reset.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[MEM_AW'(wr_addr)] <= wr_data;
        end
    end

    assign fetch_in_range = ({1'b0, iFetchAddress} < DEPTH_EXT);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oInstruction      <= NOP_WORD;
            oInstructionValid <= 1'b0;
        end else if (iFetchEnable && fsm_idle) begin
            oInstruction      <= fetch_in_range ? mem[MEM_AW'(iFetchAddress)] : NOP_WORD;
            oInstructionValid <= 1'b1;
        end else begin
            oInstruction      <= NOP_WORD;
            oInstructionValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: directed scenarios plus randomized
// fetch/load traffic compared every cycle against a transaction-level model.
module tb_program_memory;

    localparam int DEPTH = 256;
    localparam logic [27:0] NOP = 28'h0000FA0;
    localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_WRITE = 2, PH_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic [27:0] instr;
    logic        instr_valid;
    logic        ld_start = 1'b0;
    logic [15:0] ld_base = '0;
    logic [16:0] ld_count = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready, ld_busy, ld_done, ld_error;

    int checks = 0;
    int errors = 0;
    int dut_done = 0;

    always #5 clk = ~clk;

    program_memory dut (
        .Clock             (clk),
        .Reset             (rst_n),
        .iFetchEnable      (fetch_en),
        .iFetchAddress     (fetch_addr),
        .oInstruction      (instr),
        .oInstructionValid (instr_valid),
        .iLoadStart        (ld_start),
        .iLoadBase         (ld_base),
        .iLoadCount        (ld_count),
        .iLoadData         (ld_data),
        .iLoadValid        (ld_valid),
        .oLoadReady        (ld_ready),
        .oLoadBusy         (ld_busy),
        .oLoadDone         (ld_done),
        .oLoadError        (ld_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image, which words are known, and load progress.
    logic [27:0] ref_mem [DEPTH];
    bit          known [DEPTH];
    int          phase = PH_IDLE;
    int          m_base, m_cnt, m_words, m_bytes;
    logic [31:0] m_asm;
    logic [27:0] exp_instr = NOP;
    bit          exp_valid = 0, exp_known = 1, exp_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = PH_IDLE; m_bytes = 0; m_words = 0; m_asm = '0;
            exp_instr = NOP; exp_valid = 0; exp_known = 1; exp_err = 0;
        end else begin
            if (fetch_en && phase == PH_IDLE) begin
                exp_valid = 1;
                if (int'(fetch_addr) < DEPTH) begin
                    exp_instr = ref_mem[fetch_addr];
                    exp_known = known[fetch_addr];
                end else begin
                    exp_instr = NOP;
                    exp_known = 1;
                end
            end else begin
                exp_valid = 0; exp_instr = NOP; exp_known = 1;
            end
            exp_err = 0;
            case (phase)
                PH_IDLE: if (ld_start) begin
                    if (ld_count == 0) phase = PH_DONE;
                    else if (int'(ld_base) + int'(ld_count) > DEPTH) exp_err = 1;
                    else begin
                        m_base = int'(ld_base); m_cnt = int'(ld_count);
                        m_words = 0; m_bytes = 0; m_asm = '0; phase = PH_COLLECT;
                    end
                end
                PH_COLLECT: if (ld_valid) begin
                    m_asm[8*m_bytes +: 8] = ld_data;
                    m_bytes++;
                    if (m_bytes == 4) phase = PH_WRITE;
                end
                PH_WRITE: begin
                    ref_mem[m_base + m_words] = m_asm[27:0];
                    known[m_base + m_words] = 1;
                    m_words++; m_bytes = 0; m_asm = '0;
                    phase = (m_words == m_cnt) ? PH_DONE : PH_COLLECT;
                end
                default: phase = PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (ld_done) dut_done++;
        if (!rst_n) begin
            chk("rst_instr", 32'(instr), 32'(NOP));
            chk("rst_valid", 32'(instr_valid), 32'd0);
            chk("rst_ready", 32'(ld_ready), 32'd0);
            chk("rst_busy", 32'(ld_busy), 32'd0);
            chk("rst_done", 32'(ld_done), 32'd0);
            chk("rst_error", 32'(ld_error), 32'd0);
        end else begin
            chk("valid", 32'(instr_valid), 32'(exp_valid));
            if (exp_known) chk("instr", 32'(instr), 32'(exp_instr));
            chk("ready", 32'(ld_ready), 32'(phase == PH_COLLECT));
            chk("busy", 32'(ld_busy), 32'(phase != PH_IDLE));
            chk("done", 32'(ld_done), 32'(phase == PH_DONE));
            chk("error", 32'(ld_error), 32'(exp_err));
        end
    end

    task automatic step();
        @(negedge clk);
        fetch_en = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                fetch_en = 1'($urandom_range(0, 1));
                fetch_addr = 16'($urandom_range(0, 299));
                step();
            end
        end
        n = 0;
        // Bytes offered while not ready must be ignored.
        while (!ld_ready && n < 20) begin
            ld_valid = 1'b1; ld_data = 8'($urandom); n++;
            step();
        end
        if (!ld_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: oLoadReady stayed %0d, required 1", ld_ready);
        end
        ld_valid = 1'b1; ld_data = d;
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ld_busy && n < 20) begin n++; step(); end
        if (ld_busy) begin
            checks++; errors++;
            $display("FAIL busy_timeout: oLoadBusy stayed %0d, required 0", ld_busy);
        end
    endtask

    task automatic load_words(input int base, input int cnt, input logic [7:0] bytes[$], input bit gaps);
        ld_start = 1'b1; ld_base = 16'(base); ld_count = 17'(cnt);
        if (gaps) begin
            fetch_en = 1'($urandom_range(0, 1));
            fetch_addr = 16'($urandom_range(0, 299));
        end
        step();
        foreach (bytes[i]) send_byte(bytes[i], gaps);
        wait_idle();
    endtask

    task automatic fetch_chk(input int addr, input string name, input logic [27:0] exp);
        fetch_en = 1'b1; fetch_addr = 16'(addr);
        step();
        chk(name, 32'(instr), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int d0, base, cnt;

        repeat (3) @(negedge clk);
        chk("reset_instr_lit", 32'(instr), 32'h0000FA0);
        #2 rst_n = 1'b1;

        fetch_en = 1'b1; fetch_addr = 16'd0; step();
        chk("fetch0_valid", 32'(instr_valid), 32'd1);
        fetch_en = 1'b1; fetch_addr = 16'd300; step();
        chk("fetch300_instr", 32'(instr), 32'h0000FA0);
        chk("fetch300_valid", 32'(instr_valid), 32'd1);

        q = '{8'h02, 8'h23, 8'h03, 8'h0A, 8'h21, 8'h21, 8'h04, 8'h0B};
        d0 = dut_done;
        load_words(5, 2, q, 0);
        chk("load1_done_pulses", 32'(dut_done - d0), 32'd1);
        chk("model_mem5", 32'(ref_mem[5]), 32'h0A032302);
        chk("model_mem6", 32'(ref_mem[6]), 32'h0B042121);
        fetch_chk(5, "fetch5", 28'hA032302);
        fetch_chk(6, "fetch6", 28'hB042121);

        ld_start = 1'b1; ld_base = 16'd250; ld_count = 17'd7; step();
        chk("oob_error", 32'(ld_error), 32'd1);
        chk("oob_busy", 32'(ld_busy), 32'd0);
        step();
        chk("oob_error_end", 32'(ld_error), 32'd0);

        d0 = dut_done;
        ld_start = 1'b1; ld_base = 16'd40; ld_count = 17'd0; step();
        chk("zero_busy", 32'(ld_busy), 32'd1);
        chk("zero_done", 32'(ld_done), 32'd1);
        step();
        chk("zero_busy_end", 32'(ld_busy), 32'd0);
        chk("zero_done_pulses", 32'(dut_done - d0), 32'd1);

        d0 = dut_done;
        ld_start = 1'b1; ld_base = 16'd10; ld_count = 17'd2; step();
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                fetch_en = 1'b1; fetch_addr = 16'd5;
                ld_start = 1'b1; ld_base = 16'd0; ld_count = 17'd1;
            end
            send_byte(8'(i * 17 + 3), 0);
            if (i == 1) begin
                chk("collect_fetch_valid", 32'(instr_valid), 32'd0);
                chk("collect_fetch_instr", 32'(instr), 32'h0000FA0);
            end
        end
        wait_idle();
        chk("restart_done_pulses", 32'(dut_done - d0), 32'd1);
        fetch_chk(10, "fetch10", 28'h6251403);
        fetch_chk(11, "fetch11", 28'hA695847);

        ld_start = 1'b1; ld_base = 16'd30; ld_count = 17'd1;
        fetch_en = 1'b1; fetch_addr = 16'd5; step();
        chk("same_cycle_fetch", 32'(instr), 32'h0A032302);
        q = '{8'h55, 8'h66, 8'h77, 8'h08};
        foreach (q[i]) send_byte(q[i], 0);
        wait_idle();
        fetch_chk(30, "fetch30", 28'h8776655);

        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_words(21, 1, q, 0);
        d0 = dut_done;
        ld_start = 1'b1; ld_base = 16'd20; ld_count = 17'd3; step();
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(ld_busy), 32'd0);
        chk("midreset_ready", 32'(ld_ready), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        fetch_chk(20, "fetch20_kept", 28'h3A2A1A0);
        fetch_chk(21, "fetch21_unwritten", 28'h4332211);
        chk("midreset_no_done", 32'(dut_done - d0), 32'd0);

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                fetch_en = 1'($urandom_range(0, 3) != 0);
                fetch_addr = 16'($urandom_range(0, 299));
                step();
            end else begin
                base = $urandom_range(0, 259);
                cnt = $urandom_range(0, 4);
                q.delete();
                if (cnt != 0 && base + cnt <= DEPTH)
                    repeat (4 * cnt) q.push_back(8'($urandom));
                load_words(base, cnt, q, 1);
            end
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_memory.md
Name: program_memory

Overview:
- Parametrised, runtime-loadable instruction memory for the mini-processor. It is the successor to the fixed combinational instruction table.
- The fetch port gives a registered, one-cycle-latency read of DATA_WIDTH-bit instruction words. Out-of-range and blocked fetches return a NOP word.
- A byte-serial loader with a valid/ready handshake writes a contiguous block of words at runtime, so programs change without resynthesis.

Parameters:
- DATA_WIDTH, 28, instruction word width in bits.
- ADDR_WIDTH, 16, fetch/load address width.
- DEPTH, 256, number of words physically stored (DEPTH <= 2**ADDR_WIDTH).
- NOP_WORD, {4'd0, 24'd4000}, word returned for blocked or out-of-range fetches.
- BYTES_PER_WORD, ceil(DATA_WIDTH/8) = 4, derived; not overridable.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iFetchEnable  in  1  fetch request this cycle.
- iFetchAddress  in  ADDR_WIDTH  word address to fetch.
- oInstruction  out  DATA_WIDTH  fetched word.
- oInstructionValid  out  1  oInstruction holds a real fetch result.
- iLoadStart  in  1  one-cycle pulse that starts a load.
- iLoadBase  in  ADDR_WIDTH  first word address of the load; sampled with iLoadStart.
- iLoadCount  in  ADDR_WIDTH+1  number of words to load; sampled with iLoadStart.
- iLoadData  in  8  load byte, little-endian within each word.
- iLoadValid  in  1  iLoadData is valid.
- oLoadReady  out  1  a byte is accepted when iLoadValid && oLoadReady.
- oLoadBusy  out  1  a load is in progress.
- oLoadDone  out  1  one-cycle pulse on successful completion.
- oLoadError  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (asynchronous assert, Reset=0):
  - oInstruction=NOP_WORD; oInstructionValid, oLoadReady, oLoadBusy, oLoadDone, oLoadError all 0.
  - FSM goes to IDLE; byte and word counters clear.
  - Memory contents are NOT cleared and persist across reset.
- Fetch, latency 1:
  - At the edge where iFetchEnable=1 and the FSM is IDLE: oInstruction <= mem[iFetchAddress] if iFetchAddress < DEPTH, else NOP_WORD; oInstructionValid <= 1.
  - If iFetchEnable=0, or the FSM is not IDLE: oInstruction <= NOP_WORD; oInstructionValid <= 0.
- FSM states: IDLE, COLLECT, WRITE, DONE.
  - IDLE, on iLoadStart:
    - If iLoadCount == 0 -> DONE.
    - Else if iLoadBase + iLoadCount > DEPTH (compare at ADDR_WIDTH+2 bits) -> stay IDLE, pulse oLoadError next cycle, write nothing.
    - Else latch base and count, clear the byte index -> COLLECT.
  - COLLECT:
    - oLoadReady=1. Each accepted byte goes into assembly register slot byteIdx, bits [8*byteIdx +: 8].
    - Bits above DATA_WIDTH in the top byte are discarded.
    - After byte BYTES_PER_WORD-1 is accepted -> WRITE.
  - WRITE (one cycle):
    - oLoadReady=0. mem[base+wordIdx] <= assembled word; wordIdx++.
    - If wordIdx+1 == count -> DONE, else -> COLLECT with byteIdx=0.
  - DONE (one cycle): oLoadDone=1 -> IDLE.
- oLoadBusy=1 in COLLECT, WRITE and DONE.
- iLoadStart is ignored outside IDLE.
- iLoadStart and iFetchEnable in the same IDLE cycle: the fetch is served from pre-load contents; the FSM still transitions.
- Written words are visible to fetches beginning the cycle after DONE.
- Reset mid-load: already-written words remain; the partial assembly word is discarded; no oLoadDone pulse.
- Throughput: BYTES_PER_WORD+1 cycles per word with continuous iLoadValid.

Decomposition:
- Shared package/definitions file holds: the opcode constants already used by the processor (NOP, STO, LCD, ...), the default NOP_WORD, and the FSM state encodings (2-bit localparams).
- One sub-module is natural: program_memory_loader (FSM, byte assembly, bounds check). It drives write-enable, address and data into a simple synchronous RAM array kept in program_memory.

Test Plan:
- Reset, then fetch addr 0 with default contents -> one cycle later oInstructionValid=1. Fetch addr 300 (>= DEPTH 256) -> oInstruction=NOP_WORD, oInstructionValid=1.
- Load base=5, count=2, bytes 02,23,03,0A, 21,21,04,0B -> WRITE cycles write mem[5]=28'h A032302 and mem[6]=28'h B042121 (top nibble of the last byte dropped). oLoadDone pulses once. Fetch 5 then 6 returns those values.
- Load base=250, count=7 -> oLoadError pulses, oLoadBusy stays 0, mem[250..255] unchanged.
- Load count=0 -> oLoadBusy high one cycle, oLoadDone pulse, no writes.
- Fetch during COLLECT -> oInstructionValid=0, oInstruction=NOP_WORD. A second iLoadStart mid-load is ignored; the original count completes.
- Assert Reset after 1.5 words of a 3-word load -> outputs at reset values. The first word is retained, the second is not written; a following fetch confirms this.
